spi_req_arbiter: RTL and testbench
==================================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 The block SHALL have parameter SPI_TRF_BIT, default 8: SPI word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum clk cycles from issue to completion.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester request pending.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; a bit high means a transfer when the matching valid is high.
REQ-008 req_mode  in  2*NUM_REQ  per-requester mode: 01 master->slave, 10 slave->master, 11 full duplex, 00 illegal.
REQ-009 req_wdata  in  NUM_REQ*SPI_TRF_BIT  per-requester master transmit word.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_id  out  clog2(NUM_REQ)  index of the served requester.
REQ-013 rsp_mdata  out  SPI_TRF_BIT  captured spi_dout_master.
REQ-014 rsp_sdata  out  SPI_TRF_BIT  captured spi_dout_slave.
REQ-015 rsp_err  out  1  timeout or illegal mode.
REQ-016 spi_req  out  2  request to the SPI top.
REQ-017 spi_din_master  out  SPI_TRF_BIT  master transmit word.
REQ-018 spi_dout_master, spi_dout_slave, spi_done_tx, spi_done_rx  in  SPI_TRF_BIT/1  SPI top outputs.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE SHALL grant round-robin: the lowest index at or after ptr+1 (mod NUM_REQ) with valid high; ptr resets to NUM_REQ-1, so index 0 wins first.
REQ-022 In IDLE, req_ready SHALL be high only for the granted index, in the same cycle as its valid (one-hot); req_ready SHALL be all-zero in every other state.
REQ-023 On handshake, the block SHALL latch mode, wdata and id, set ptr to id, and go to ISSUE the next cycle.
REQ-024 Illegal mode 00 SHALL skip SPI entirely: go directly to RESP with rsp_err=1 and rsp_mdata/rsp_sdata=0.
REQ-025 ISSUE SHALL last exactly one cycle with spi_req equal to the latched mode; spi_req SHALL be 00 in all other states.
REQ-026 spi_din_master SHALL be driven with the latched wdata from ISSUE until the exit from WAIT, and SHALL hold its value otherwise.
REQ-027 Completion SHALL be detected on rising edges of spi_done_tx and spi_done_rx, using registered previous values that track continuously from reset.
REQ-028 In WAIT, a rising edge of done_tx SHALL set tx_seen and capture spi_dout_slave; a rising edge of done_rx SHALL set rx_seen and capture spi_dout_master.
REQ-029 WAIT SHALL exit to RESP when the seen flags required by the mode are set: 01 needs tx, 10 needs rx, 11 needs both in any order or simultaneously.
REQ-030 Edges that the mode does not require SHALL be ignored and SHALL NOT be captured.
REQ-031 The timeout counter SHALL clear in ISSUE and increment each WAIT cycle.
REQ-032 When the count reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with rsp_err=1; captures already made SHALL be kept and missing data SHALL be 0.
REQ-033 If completion and timeout occur in the same cycle, completion SHALL win and rsp_err SHALL be 0.
REQ-034 rsp_valid SHALL rise the cycle after WAIT exits and hold with stable rsp_id/rsp_mdata/rsp_sdata/rsp_err until rsp_ready is high; the FSM SHALL then return to IDLE.
REQ-035 The block SHALL grant no new request while in RESP; at most one transaction SHALL be outstanding.
REQ-036 Latency from handshake to spi_req SHALL be exactly 1 cycle.

Reset
REQ-037 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, ptr SHALL be NUM_REQ-1, and seen flags, captures, edge registers and counter SHALL be 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no response; spi_req SHALL drop to 00 asynchronously.

Verification
REQ-039 Single transfer: req_valid[2]=1, mode 01, wdata A5; done_tx rises with dout_slave=A5 -> spi_req=01 for 1 cycle, then rsp_id=2, rsp_sdata=A5, rsp_err=0.
REQ-040 Fairness: all 4 valids held high with mode 11 -> grant order 0,1,2,3,0; no grant during WAIT or RESP.
REQ-041 Duplex edge ordering: mode 11 with done_rx 30 cycles before done_tx, then both in the same cycle -> exactly one response per transaction with both words captured.
REQ-042 Timeout: mode 10 with done_rx held low -> rsp_err=1 exactly TIMEOUT_CYCLES WAIT cycles after ISSUE, rsp_mdata=0; if done_rx rises on the final cycle -> rsp_err=0.
REQ-043 Backpressure and illegal mode: rsp_ready held low for 20 cycles -> response stable and req_ready=0 throughout; mode 00 -> spi_req never asserted and rsp_err=1.
REQ-044 Reset mid-WAIT: assert rst_n=0 -> all outputs 0 with no response; after release, the first grant is index 0.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
// Requester/response bus for spi_req_arbiter. The slave modport is the arbiter side,
// the master modport is the requester side.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int SPI_TRF_BIT = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [2*NUM_REQ-1:0]           req_mode;
    logic [NUM_REQ*SPI_TRF_BIT-1:0] req_wdata;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ID_W-1:0]                rsp_id;
    logic [SPI_TRF_BIT-1:0]         rsp_mdata;
    logic [SPI_TRF_BIT-1:0]         rsp_sdata;
    logic                           rsp_err;

    modport slave (
        input  req_valid, req_mode, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_mdata, rsp_sdata, rsp_err
    );

    modport master (
        output req_valid, req_mode, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_mdata, rsp_sdata, rsp_err
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that serialises requester transfers onto one SPI top and
// returns one response (captured words, timeout/illegal error) per transfer.
module spi_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SPI_TRF_BIT    = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_req_arbiter_if.slave       bus,
    output logic [1:0]             spi_req,
    output logic [SPI_TRF_BIT-1:0] spi_din_master,
    input  logic [SPI_TRF_BIT-1:0] spi_dout_master,
    input  logic [SPI_TRF_BIT-1:0] spi_dout_slave,
    input  logic                   spi_done_tx,
    input  logic                   spi_done_rx,
    output logic                   busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SW    = ID_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    logic [1:0]             r_mode;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_tx_seen;
    logic                   r_rx_seen;
    logic                   r_prev_tx;
    logic                   r_prev_rx;
    logic [SPI_TRF_BIT-1:0] r_mdata;
    logic [SPI_TRF_BIT-1:0] r_sdata;
    logic                   r_err;
    logic                   r_rsp_valid;
    logic [1:0]             r_spi_req;
    logic [SPI_TRF_BIT-1:0] r_din;

    logic [1:0]             w_mode_arr  [NUM_REQ];
    logic [SPI_TRF_BIT-1:0] w_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_mode_arr[gi]  = bus.req_mode[2*gi +: 2];
            assign w_wdata_arr[gi] = bus.req_wdata[gi*SPI_TRF_BIT +: SPI_TRF_BIT];
        end
    endgenerate

    // Rotate the valid vector so bit 0 is the index right after ptr, then pick the lowest.
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SW-1:0]        w_ptr_p1;
    logic [SW-1:0]        w_sum;
    logic [ID_W-1:0]      w_off;
    logic [ID_W-1:0]      w_gnt_id;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_ready;

    assign w_dbl    = {bus.req_valid, bus.req_valid};
    assign w_ptr_p1 = {1'b0, r_ptr} + SW'(1);
    assign w_rot    = NUM_REQ'(w_dbl >> w_ptr_p1);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
    end

    assign w_sum    = w_ptr_p1 + {1'b0, w_off};
    assign w_gnt_id = (w_sum >= SW'(NUM_REQ)) ? ID_W'(w_sum - SW'(NUM_REQ)) : ID_W'(w_sum);
    assign w_ready  = (rst_n && (r_state == ST_IDLE) && w_found) ?
                      (NUM_REQ'(1) << w_gnt_id) : '0;

    logic [1:0]             w_mode_sel;
    logic [SPI_TRF_BIT-1:0] w_wdata_sel;
    assign w_mode_sel  = w_mode_arr[w_gnt_id];
    assign w_wdata_sel = w_wdata_arr[w_gnt_id];

    // Mode bit 0 demands the done_tx edge, bit 1 the done_rx edge.
    logic w_need_tx, w_need_rx, w_rise_tx, w_rise_rx;
    logic w_tx_seen_n, w_rx_seen_n, w_done, w_tmo;
    assign w_need_tx   = r_mode[0];
    assign w_need_rx   = r_mode[1];
    assign w_rise_tx   = spi_done_tx & ~r_prev_tx;
    assign w_rise_rx   = spi_done_rx & ~r_prev_rx;
    assign w_tx_seen_n = r_tx_seen | (w_need_tx & w_rise_tx);
    assign w_rx_seen_n = r_rx_seen | (w_need_rx & w_rise_rx);
    assign w_done      = (~w_need_tx | w_tx_seen_n) & (~w_need_rx | w_rx_seen_n);
    assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_mode      <= '0;
            r_cnt       <= '0;
            r_tx_seen   <= 1'b0;
            r_rx_seen   <= 1'b0;
            r_prev_tx   <= 1'b0;
            r_prev_rx   <= 1'b0;
            r_mdata     <= '0;
            r_sdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_spi_req   <= '0;
            r_din       <= '0;
        end else begin
            r_prev_tx <= spi_done_tx;
            r_prev_rx <= spi_done_rx;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_gnt_id;
                        r_mode  <= w_mode_sel;
                        r_mdata <= '0;
                        r_sdata <= '0;
                        if (w_mode_sel == 2'b00) begin
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_din     <= w_wdata_sel;
                            r_spi_req <= w_mode_sel;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_spi_req <= 2'b00;
                    r_cnt     <= '0;
                    r_tx_seen <= 1'b0;
                    r_rx_seen <= 1'b0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tx_seen <= w_tx_seen_n;
                    r_rx_seen <= w_rx_seen_n;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_need_tx && w_rise_tx) r_sdata <= spi_dout_slave;
                    if (w_need_rx && w_rise_rx) r_mdata <= spi_dout_master;
                    // Completion takes precedence over a coincident timeout.
                    if (w_done) begin
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_tmo) begin
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_mdata   = r_mdata;
    assign bus.rsp_sdata   = r_sdata;
    assign bus.rsp_err     = r_err;
    assign spi_req         = r_spi_req;
    assign spi_din_master  = r_din;
    assign busy            = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed plus randomized transactions checked against a rule-level model of
// grant order, completion/timeout time and captured response data.
module tb_spi_req_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   spi_req;
    logic [W-1:0] spi_din_master;
    logic [W-1:0] spi_dout_master = '0;
    logic [W-1:0] spi_dout_slave = '0;
    logic         spi_done_tx = 1'b0;
    logic         spi_done_rx = 1'b0;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = N - 1;

    spi_req_arbiter_if #(.NUM_REQ(N), .SPI_TRF_BIT(W)) bus ();

    spi_req_arbiter #(.NUM_REQ(N), .SPI_TRF_BIT(W), .TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .spi_req         (spi_req),
        .spi_din_master  (spi_din_master),
        .spi_dout_master (spi_dout_master),
        .spi_dout_slave  (spi_dout_slave),
        .spi_done_tx     (spi_done_tx),
        .spi_done_rx     (spi_done_rx),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] all_outs();
        return {spi_req, busy, bus.rsp_valid, bus.rsp_err, bus.rsp_id,
                bus.rsp_mdata, bus.rsp_sdata, bus.req_ready, spi_din_master};
    endfunction

    // tx_at/rx_at: WAIT cycle (1..T) in which done rises; 0 means never.
    task automatic txn(input logic [N-1:0] vld, input logic [2*N-1:0] modes,
                       input logic [N*W-1:0] wds, input int tx_at, input int rx_at,
                       input logic [W-1:0] sval, input logic [W-1:0] mval, input int hold);
        int gid, t_tx, t_rx, last, exit_c, exp_resp, seen;
        logic [1:0] md;
        logic [W-1:0] exp_m, exp_s;
        logic exp_err, bad_spi, bad_rdy, bad_hold;
        bus.req_valid = vld;
        bus.req_mode  = modes;
        bus.req_wdata = wds;
        bus.rsp_ready = 1'b0;
        gid = model_grant(vld);
        #1;
        chk("idle_busy", busy, 0);
        chk("grant_onehot", bus.req_ready, 64'(1) << gid);
        md = modes[2*gid +: 2];
        m_ptr = gid;
        if (md == 2'b00) begin
            exit_c = -1; exp_err = 1'b1; exp_m = '0; exp_s = '0;
        end else begin
            t_tx = !md[0] ? 0 : ((tx_at >= 1 && tx_at <= T) ? tx_at : T + 1000);
            t_rx = !md[1] ? 0 : ((rx_at >= 1 && rx_at <= T) ? rx_at : T + 1000);
            last = (t_tx > t_rx) ? t_tx : t_rx;
            exit_c  = (last <= T) ? last : T;
            exp_err = (last > T);
            exp_s = (md[0] && tx_at >= 1 && tx_at <= exit_c) ? sval : '0;
            exp_m = (md[1] && rx_at >= 1 && rx_at <= exit_c) ? mval : '0;
        end
        exp_resp = exit_c + 1;
        @(negedge clk);
        chk("spi_req_issue", spi_req, md);
        if (md != 2'b00) chk("din_master", spi_din_master, wds[gid*W +: W]);
        seen = -1; bad_spi = 1'b0; bad_rdy = 1'b0;
        for (int j = 0; j <= T + 4; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.req_ready !== '0) bad_rdy = 1'b1;
            if (j > 0 && spi_req !== 2'b00) bad_spi = 1'b1;
            if (bus.rsp_valid === 1'b1) begin
                seen = j;
                break;
            end
            spi_done_tx     = (j > 0 && j == tx_at);
            spi_done_rx     = (j > 0 && j == rx_at);
            spi_dout_slave  = (j == tx_at) ? sval : W'($urandom);
            spi_dout_master = (j == rx_at) ? mval : W'($urandom);
        end
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        chk("rsp_latency", 64'(seen), 64'(exp_resp));
        chk("rsp_id", bus.rsp_id, gid);
        chk("rsp_mdata", bus.rsp_mdata, exp_m);
        chk("rsp_sdata", bus.rsp_sdata, exp_s);
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("spi_req_one_cycle", bad_spi, 0);
        chk("no_grant_when_busy", bad_rdy, 0);
        bad_hold = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(gid) || bus.rsp_mdata !== exp_m ||
                bus.rsp_sdata !== exp_s || bus.rsp_err !== exp_err || bus.req_ready !== '0)
                bad_hold = 1'b1;
        end
        if (hold > 0) chk("rsp_hold_stable", bad_hold, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        chk("rsp_released", {bus.rsp_valid, busy}, 0);
        $display("txn id=%0d mode=%b tx_at=%0d rx_at=%0d err=%0b mdata=%0h sdata=%0h",
                 gid, md, tx_at, rx_at, exp_err, exp_m, exp_s);
    endtask

    task automatic reset_mid(input logic [N-1:0] vld, input int waitn);
        int gid;
        bus.req_valid = vld;
        bus.req_mode  = {N{2'b11}};
        bus.req_wdata = {N{8'h3C}};
        gid = model_grant(vld);
        #1;
        chk("rst_pre_grant", bus.req_ready, 64'(1) << gid);
        @(negedge clk);
        repeat (waitn) @(negedge clk);
        bus.req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", all_outs(), 0);
        m_ptr = N - 1;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_response", {bus.rsp_valid, busy}, 0);
        $display("reset after %0d cycles past issue", waitn);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_mode  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("reset_outputs", all_outs(), 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single master->slave transfer from requester 2
        txn(4'b0100, {N{2'b01}}, {N{8'hA5}}, 4, 0, 8'hA5, 8'h00, 0);

        // reset in ISSUE (spi_req must drop immediately) and mid-WAIT
        reset_mid(4'b0010, 0);
        reset_mid(4'b1000, 6);

        // fairness with all valids held: expect 0,1,2,3,0
        for (int i = 0; i < 5; i++)
            txn(4'b1111, {N{2'b11}}, {$urandom, $urandom}, 5, 6, W'($urandom), W'($urandom), 1);

        // duplex: rx 30 cycles before tx, then both together
        txn(4'b0001, {N{2'b11}}, {$urandom, $urandom}, 33, 3, 8'h5A, 8'hC3, 0);
        txn(4'b0010, {N{2'b11}}, {$urandom, $urandom}, 7, 7, 8'h11, 8'h22, 0);

        // timeout, completion on final cycle, partial capture on timeout
        txn(4'b0100, {N{2'b10}}, {$urandom, $urandom}, 0, 0, 8'h77, 8'h88, 0);
        txn(4'b0100, {N{2'b10}}, {$urandom, $urandom}, 0, T, 8'h77, 8'h99, 0);
        txn(4'b1000, {N{2'b11}}, {$urandom, $urandom}, 10, 0, 8'h6D, 8'h44, 0);

        // backpressure, illegal mode, edges the mode does not need
        txn(4'b0001, {N{2'b01}}, {$urandom, $urandom}, 3, 0, 8'hE7, 8'h00, 20);
        txn(4'b0010, {N{2'b00}}, {$urandom, $urandom}, 2, 2, 8'hFF, 8'hFF, 3);
        txn(4'b0100, {N{2'b01}}, {$urandom, $urandom}, 8, 2, 8'h12, 8'h34, 0);
        txn(4'b1000, {N{2'b10}}, {$urandom, $urandom}, 2, 5, 8'h56, 8'h78, 0);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] v;
            int ta, ra;
            v  = N'($urandom_range(1, (1 << N) - 1));
            ta = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T);
            ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T);
            txn(v, 8'($urandom), {$urandom, $urandom}, ta, ra,
                W'($urandom), W'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
